axi4_burst_master: RTL and testbench

- AXI4 initiator that drives the team's AXI4 memory-mapped slave from a simple command/data interface.
- Accepts one write or read burst command at a time.
- Issues INCR bursts on the AW/W/B or AR/R channels and reports completion with a response code.
- Used as the stimulus/traffic engine in front of the slave, opposite end of the same AXI4 link.

---
 rtl/axi4_burst_master_if.sv | 62 ++++++
 rtl/axi4_burst_master.sv | 179 +++++++++++++++++
 tb/tb_axi4_burst_master.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_burst_master_if.sv
// AXI4 link between the burst master and a memory-mapped slave.
// The master modport drives AW/W/AR and the B/R ready strobes.
interface axi4_burst_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;

  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARVALID;
  logic                    ARREADY;

  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi4_burst_master.sv
// AXI4 INCR-burst initiator: one write or read command at a time,
// completion reported by a one-cycle done pulse with a response code.
module axi4_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done,
  output logic [1:0]            done_resp,
  axi4_burst_master_if.master   axi
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_ERR
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic [1:0]            r_rresp;
  logic                  r_done;
  logic [1:0]            r_done_resp;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_last;

  logic                  w_accept;
  logic                  w_unaligned;
  logic                  w_cross_4k;
  logic [31:0]           w_end;
  logic                  w_w_hs;
  logic [1:0]            w_rresp_max;

  // Burst end offset within its 4KB page; ending exactly on the boundary is legal.
  assign w_end       = 32'(cmd_addr[11:0]) + ((32'(cmd_len) + 32'd1) << SIZE);
  assign w_cross_4k  = w_end > 32'd4096;
  assign w_unaligned = (cmd_addr & ADDR_WIDTH'(BYTES - 1)) != '0;
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_w_hs      = axi.WVALID && axi.WREADY;
  assign w_rresp_max = (axi.RRESP > r_rresp) ? axi.RRESP : r_rresp;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    // Held off during reset and during the done cycle so a new command lands after it.
    cmd_ready    = ARESETn && (r_state == S_IDLE) && !r_done;
    wr_ready     = 1'b0;
    axi.AWADDR   = r_addr;
    axi.AWLEN    = r_len;
    axi.AWSIZE   = 3'(SIZE);
    axi.AWBURST  = 2'b01;
    axi.AWVALID  = 1'b0;
    axi.WDATA    = '0;
    axi.WSTRB    = '1;
    axi.WLAST    = 1'b0;
    axi.WVALID   = 1'b0;
    axi.BREADY   = 1'b0;
    axi.ARADDR   = r_addr;
    axi.ARLEN    = r_len;
    axi.ARSIZE   = 3'(SIZE);
    axi.ARBURST  = 2'b01;
    axi.ARVALID  = 1'b0;
    axi.RREADY   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_unaligned || w_cross_4k) w_state_nxt = S_ERR;
          else if (cmd_write)            w_state_nxt = S_AW;
          else                           w_state_nxt = S_AR;
        end
      end
      S_AW: begin
        axi.AWVALID = 1'b1;
        if (axi.AWREADY) w_state_nxt = S_W;
      end
      S_W: begin
        axi.WVALID = wr_valid;
        axi.WDATA  = wr_data;
        axi.WLAST  = (r_beat == r_len);
        wr_ready   = axi.WREADY;
        if (w_w_hs && (r_beat == r_len)) w_state_nxt = S_B;
      end
      S_B: begin
        axi.BREADY = 1'b1;
        if (axi.BVALID) w_state_nxt = S_IDLE;
      end
      S_AR: begin
        axi.ARVALID = 1'b1;
        if (axi.ARREADY) w_state_nxt = S_R;
      end
      S_R: begin
        axi.RREADY = 1'b1;
        if (axi.RVALID && axi.RLAST) w_state_nxt = S_IDLE;
      end
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_addr      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_rresp     <= '0;
      r_done      <= 1'b0;
      r_done_resp <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_rd_last   <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      if (w_accept) begin
        r_addr  <= cmd_addr;
        r_len   <= cmd_len;
        r_beat  <= '0;
        r_rresp <= '0;
      end
      case (r_state)
        S_W: if (w_w_hs) r_beat <= r_beat + 8'd1;
        S_B: begin
          if (axi.BVALID) begin
            r_done      <= 1'b1;
            r_done_resp <= axi.BRESP;
          end
        end
        S_R: begin
          if (axi.RVALID) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= axi.RDATA;
            r_rd_last  <= axi.RLAST;
            r_beat     <= r_beat + 8'd1;
            r_rresp    <= w_rresp_max;
            // A short or long burst from the slave is reported as SLVERR.
            if (axi.RLAST) begin
              r_done      <= 1'b1;
              r_done_resp <= (r_beat != r_len) ? 2'b10 : w_rresp_max;
            end
          end
        end
        S_ERR: begin
          r_done      <= 1'b1;
          r_done_resp <= 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_last   = r_rd_last;
  assign done      = r_done;
  assign done_resp = r_done_resp;

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master: the bench plays the AXI slave
// cycle by cycle and checks every master output against hand-derived values.
module tb_axi4_burst_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_last, done;
  logic [31:0] rd_data;
  logic [1:0]  done_resp;

  int n_cmp = 0;
  int n_err = 0;
  int aw_seen = 0, ar_seen = 0, w_hs = 0, done_cnt = 0;

  axi4_burst_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) axi ();

  axi4_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .ACLK(clk), .ARESETn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_resp(done_resp),
    .axi(axi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (axi.AWVALID)             aw_seen  <= aw_seen + 1;
    if (axi.ARVALID)             ar_seen  <= ar_seen + 1;
    if (axi.WVALID && axi.WREADY) w_hs    <= w_hs + 1;
    if (done)                    done_cnt <= done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h11111111 * 32'(i + 1);
  endfunction

  task automatic wr_burst(input string tag, input logic [15:0] addr, input logic [7:0] len,
                          input int stall, input bit toggle, input logic [31:0] first_word,
                          input logic [1:0] bresp);
    int i;
    int hs0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len;
    #1 chk({tag, "_cmdrdy"}, 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    for (int s = 0; s < stall; s++) begin
      #1 chk({tag, "_awstall_v"}, 64'(axi.AWVALID), 64'd1);
      chk({tag, "_awstall_a"}, 64'(axi.AWADDR), 64'(addr));
      tick();
    end
    axi.AWREADY = 1'b1;
    #1 chk({tag, "_awvalid"}, 64'(axi.AWVALID), 64'd1);
    chk({tag, "_awaddr"}, 64'(axi.AWADDR), 64'(addr));
    chk({tag, "_awlen"}, 64'(axi.AWLEN), 64'(len));
    chk({tag, "_awsize"}, 64'(axi.AWSIZE), 64'd2);
    chk({tag, "_awburst"}, 64'(axi.AWBURST), 64'd1);
    chk({tag, "_busy"}, 64'(cmd_ready), 64'd0);
    tick();
    axi.AWREADY = 1'b0;
    axi.WREADY = 1'b1;
    hs0 = w_hs;
    i = 0;
    for (int c = 0; c < 2 * (int'(len) + 1) + 2 && i <= int'(len); c++) begin
      wr_valid = toggle ? ((c % 2) == 0) : 1'b1;
      wr_data  = (i == 0) ? first_word : pat(i);
      #1 chk({tag, "_wvalid"}, 64'(axi.WVALID), 64'(wr_valid));
      if (wr_valid) begin
        chk({tag, "_wdata"}, 64'(axi.WDATA), 64'(wr_data));
        chk({tag, "_wlast"}, 64'(axi.WLAST), 64'(i == int'(len)));
        chk({tag, "_wstrb"}, 64'(axi.WSTRB), 64'hF);
        chk({tag, "_wrrdy"}, 64'(wr_ready), 64'd1);
      end
      tick();
      if (wr_valid) i++;
    end
    wr_valid = 1'b0;
    axi.WREADY = 1'b0;
    chk({tag, "_whs"}, 64'(w_hs - hs0), 64'(int'(len) + 1));
    axi.BVALID = 1'b1; axi.BRESP = bresp;
    #1 chk({tag, "_bready"}, 64'(axi.BREADY), 64'd1);
    tick();
    axi.BVALID = 1'b0; axi.BRESP = 2'b00;
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_resp"}, 64'(done_resp), 64'(bresp));
    tick();
    chk({tag, "_done_off"}, 64'(done), 64'd0);
    chk({tag, "_cmdrdy2"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic rd_burst(input string tag, input logic [15:0] addr, input logic [7:0] len,
                          input int nbeats, input int stall, input logic [7:0] resps,
                          input logic [1:0] exp_resp);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
    #1 chk({tag, "_cmdrdy"}, 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    for (int s = 0; s < stall; s++) begin
      #1 chk({tag, "_arstall_v"}, 64'(axi.ARVALID), 64'd1);
      chk({tag, "_arstall_a"}, 64'(axi.ARADDR), 64'(addr));
      tick();
    end
    axi.ARREADY = 1'b1;
    #1 chk({tag, "_arvalid"}, 64'(axi.ARVALID), 64'd1);
    chk({tag, "_araddr"}, 64'(axi.ARADDR), 64'(addr));
    chk({tag, "_arlen"}, 64'(axi.ARLEN), 64'(len));
    chk({tag, "_arsize"}, 64'(axi.ARSIZE), 64'd2);
    chk({tag, "_arburst"}, 64'(axi.ARBURST), 64'd1);
    tick();
    axi.ARREADY = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      axi.RVALID = 1'b1;
      axi.RDATA  = pat(i);
      axi.RLAST  = (i == nbeats - 1);
      axi.RRESP  = resps[2*i +: 2];
      #1 chk({tag, "_rready"}, 64'(axi.RREADY), 64'd1);
      tick();
      chk({tag, "_rdvalid"}, 64'(rd_valid), 64'd1);
      chk({tag, "_rddata"}, 64'(rd_data), 64'(pat(i)));
      chk({tag, "_rdlast"}, 64'(rd_last), 64'(i == nbeats - 1));
      chk({tag, "_done"}, 64'(done), 64'(i == nbeats - 1));
      if (i == nbeats - 1) chk({tag, "_resp"}, 64'(done_resp), 64'(exp_resp));
    end
    axi.RVALID = 1'b0; axi.RLAST = 1'b0; axi.RRESP = 2'b00;
    tick();
    chk({tag, "_rdvalid_off"}, 64'(rd_valid), 64'd0);
    chk({tag, "_done_off"}, 64'(done), 64'd0);
    chk({tag, "_cmdrdy2"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic err_cmd(input string tag, input bit wr, input logic [15:0] addr,
                         input logic [7:0] len);
    int aw0;
    int ar0;
    aw0 = aw_seen; ar0 = ar_seen;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_done_early"}, 64'(done), 64'd0);
    chk({tag, "_busy"}, 64'(cmd_ready), 64'd0);
    tick();
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_resp"}, 64'(done_resp), 64'h2);
    tick();
    chk({tag, "_done_off"}, 64'(done), 64'd0);
    chk({tag, "_cmdrdy"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_no_aw"}, 64'(aw_seen - aw0), 64'd0);
    chk({tag, "_no_ar"}, 64'(ar_seen - ar0), 64'd0);
  endtask

  initial begin
    int d0;
    rstn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0; axi.BRESP = 2'b00;
    axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RDATA = '0; axi.RRESP = 2'b00; axi.RLAST = 1'b0;

    tick(); tick();
    chk("rst_cmdrdy", 64'(cmd_ready), 64'd0);
    chk("rst_awvalid", 64'(axi.AWVALID), 64'd0);
    chk("rst_arvalid", 64'(axi.ARVALID), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_resp", 64'(done_resp), 64'd0);
    chk("rst_rdvalid", 64'(rd_valid), 64'd0);
    chk("rst_awaddr", 64'(axi.AWADDR), 64'd0);
    rstn = 1'b1;
    tick();
    chk("idle_cmdrdy", 64'(cmd_ready), 64'd1);

    wr_burst("w1", 16'h0010, 8'd0, 0, 1'b0, 32'hDEADBEEF, 2'b00);
    wr_burst("w4", 16'h0100, 8'd3, 2, 1'b0, 32'h11111111, 2'b00);
    rd_burst("r4", 16'h0100, 8'd3, 4, 2, 8'b00_00_00_00, 2'b00);
    rd_burst("rresp", 16'h0200, 8'd3, 4, 0, 8'b00_00_10_00, 2'b10);
    rd_burst("rshort", 16'h0300, 8'd3, 2, 0, 8'b00_00_00_00, 2'b10);
    err_cmd("e4k", 1'b1, 16'h0FF8, 8'd3);
    err_cmd("eunal", 1'b0, 16'h0002, 8'd0);
    wr_burst("w4k_edge", 16'h0FF0, 8'd3, 0, 1'b0, 32'h11111111, 2'b01);
    wr_burst("wtog", 16'h0400, 8'd3, 0, 1'b1, 32'h11111111, 2'b00);

    // Reset in the middle of an 8-beat write, after two data beats.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0500; cmd_len = 8'd7;
    tick();
    cmd_valid = 1'b0;
    axi.AWREADY = 1'b1;
    tick();
    axi.AWREADY = 1'b0;
    axi.WREADY = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_data = pat(i);
      tick();
    end
    d0 = done_cnt;
    rstn = 1'b0;
    #1 chk("mrst_cmdrdy", 64'(cmd_ready), 64'd0);
    tick();
    chk("mrst_awvalid", 64'(axi.AWVALID), 64'd0);
    chk("mrst_wvalid", 64'(axi.WVALID), 64'd0);
    chk("mrst_wrrdy", 64'(wr_ready), 64'd0);
    chk("mrst_bready", 64'(axi.BREADY), 64'd0);
    chk("mrst_arvalid", 64'(axi.ARVALID), 64'd0);
    chk("mrst_rready", 64'(axi.RREADY), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    wr_valid = 1'b0; axi.WREADY = 1'b0;
    rstn = 1'b1;
    tick();
    chk("mrst_cmdrdy2", 64'(cmd_ready), 64'd1);
    chk("mrst_no_done", 64'(done_cnt - d0), 64'd0);
    rd_burst("rpost", 16'h0040, 8'd0, 1, 0, 8'b00, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
